piece_mover: RTL and testbench

PIECE_MOVER -- requirements
Module: piece_mover

---
 rtl/piece_mover.sv | 170 +++++++++++++++++
 tb/tb_piece_mover.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_mover.sv
// Falling-piece sprite controller: keyboard-driven moves, gravity, hard drop and
// landing, plus registered sprite bounds and ROM address for the pixel scanner.
module piece_mover #(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int STEP        = 16,
    parameter int SCR_W       = 640,
    parameter int SCR_H       = 480,
    parameter int DROP_FRAMES = 30,
    parameter int WRAP_H      = 0,
    parameter int X0          = 288,
    parameter int Y0          = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [8:0]  key_code,
    input  logic        frame_start,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    output logic [9:0]  left_most,
    output logic [9:0]  right_most,
    output logic [9:0]  up_most,
    output logic [9:0]  down_most,
    output logic        in_win,
    output logic [16:0] pixel_addr,
    output logic        landed
);
    localparam logic [9:0] X_MAX    = 10'(SCR_W - SPR_W);
    localparam logic [9:0] Y_MAX    = 10'(SCR_H - SPR_H);
    localparam logic [9:0] X_SPAWN  = 10'(X0);
    localparam logic [9:0] Y_SPAWN  = 10'(Y0);
    localparam logic [9:0] STEP_V   = 10'(STEP);
    localparam logic [9:0] W_M1     = 10'(SPR_W - 1);
    localparam logic [9:0] H_M1     = 10'(SPR_H - 1);
    localparam logic [7:0] CNT_LAST = 8'(DROP_FRAMES - 1);

    typedef enum logic [1:0] {FALL, DROP, LANDED} state_t;
    typedef enum logic [2:0] {CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_HARD} cmd_t;

    state_t      state_q, state_d;
    cmd_t        pend_q, pend_d, key_cmd;
    logic        arm_q, arm_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  left_most_q, right_most_q, up_most_q, down_most_q;
    logic        in_win_q, in_win_d;
    logic [16:0] pixel_addr_q, pixel_addr_d;
    logic [10:0] x_plus, y_plus;
    logic [9:0]  x_left, x_right, y_down;
    logic [9:0]  dx, dy;
    logic        grav_tick;

    always_comb begin
        case (key_code)
            9'h16B:  key_cmd = CMD_LEFT;
            9'h174:  key_cmd = CMD_RIGHT;
            9'h172:  key_cmd = CMD_DOWN;
            9'h029:  key_cmd = CMD_HARD;
            default: key_cmd = CMD_NONE;
        endcase
    end

    // Candidate positions one step away, clamped (or wrapped) at the screen edges.
    always_comb begin
        x_plus  = {1'b0, x_q} + {1'b0, STEP_V};
        y_plus  = {1'b0, y_q} + {1'b0, STEP_V};
        x_left  = (x_q < STEP_V) ? '0 : x_q - STEP_V;
        x_right = (x_plus > {1'b0, X_MAX}) ? X_MAX : x_plus[9:0];
        y_down  = (y_plus > {1'b0, Y_MAX}) ? Y_MAX : y_plus[9:0];
        if (WRAP_H != 0) begin
            if (x_q == '0)
                x_left = X_MAX;
            if (x_q == X_MAX)
                x_right = '0;
        end
    end

    assign grav_tick = frame_start && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        arm_d   = arm_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        if (frame_start) begin
            cnt_d  = grav_tick ? '0 : cnt_q + 8'd1;
            pend_d = CMD_NONE;
            case (state_q)
                FALL: begin
                    if (pend_q == CMD_LEFT)
                        x_d = x_left;
                    if (pend_q == CMD_RIGHT)
                        x_d = x_right;
                    if (pend_q == CMD_DOWN || grav_tick)
                        y_d = y_down;
                    if (pend_q == CMD_HARD)
                        state_d = DROP;
                end
                DROP:
                    y_d = y_down;
                default: begin
                    if (arm_q) begin
                        x_d     = X_SPAWN;
                        y_d     = Y_SPAWN;
                        cnt_d   = '0;
                        arm_d   = 1'b0;
                        state_d = FALL;
                    end
                end
            endcase
            if (state_q != LANDED && y_d == Y_MAX)
                state_d = LANDED;
        end
        // A key seen while (or as) the piece is landed only arms the re-spawn.
        if (key_valid) begin
            if (state_d == LANDED)
                arm_d = 1'b1;
            else if (key_cmd != CMD_NONE)
                pend_d = key_cmd;
        end
    end

    always_comb begin
        dx           = h_cnt - x_q;
        dy           = v_cnt - y_q;
        in_win_d     = (h_cnt >= x_q) && (dx <= W_M1) && (v_cnt >= y_q) && (dy <= H_M1);
        pixel_addr_d = in_win_d ? 17'(dx) + 17'(SPR_W) * 17'(dy) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FALL;
            pend_q       <= CMD_NONE;
            arm_q        <= 1'b0;
            cnt_q        <= '0;
            x_q          <= X_SPAWN;
            y_q          <= Y_SPAWN;
            left_most_q  <= X_SPAWN;
            right_most_q <= X_SPAWN + W_M1;
            up_most_q    <= Y_SPAWN;
            down_most_q  <= Y_SPAWN + H_M1;
            in_win_q     <= 1'b0;
            pixel_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            arm_q        <= arm_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            left_most_q  <= x_d;
            right_most_q <= x_d + W_M1;
            up_most_q    <= y_d;
            down_most_q  <= y_d + H_M1;
            in_win_q     <= in_win_d;
            pixel_addr_q <= pixel_addr_d;
        end
    end

    assign left_most  = left_most_q;
    assign right_most = right_most_q;
    assign up_most    = up_most_q;
    assign down_most  = down_most_q;
    assign in_win     = in_win_q;
    assign pixel_addr = pixel_addr_q;
    assign landed     = (state_q == LANDED);
endmodule

// File: tb/tb_piece_mover.sv
// Self-checking bench for piece_mover: three instances (clamp, wrap, fast gravity)
// share stimulus; directed scenario tasks plus a randomized run against a model.
module tb_piece_mover;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [8:0]  key_code = '0;
    logic        frame_start = 1'b0;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic [9:0]  lm [3];
    logic [9:0]  rm [3];
    logic [9:0]  um [3];
    logic [9:0]  dm [3];
    logic        iw [3];
    logic        ld [3];
    logic [16:0] pa [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piece_mover u_def (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .left_most(lm[0]), .right_most(rm[0]), .up_most(um[0]), .down_most(dm[0]),
        .in_win(iw[0]), .pixel_addr(pa[0]), .landed(ld[0]));

    piece_mover #(.WRAP_H(1)) u_wrap (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .left_most(lm[1]), .right_most(rm[1]), .up_most(um[1]), .down_most(dm[1]),
        .in_win(iw[1]), .pixel_addr(pa[1]), .landed(ld[1]));

    piece_mover #(.DROP_FRAMES(2)) u_fast (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .left_most(lm[2]), .right_most(rm[2]), .up_most(um[2]), .down_most(dm[2]),
        .in_win(iw[2]), .pixel_addr(pa[2]), .landed(ld[2]));

    localparam int XMAX = 576;
    localparam int YMAX = 416;

    // Reference model: position, mode (0 fall, 1 drop, 2 landed), frame count,
    // pending command (0 none, 1 left, 2 right, 3 down, 4 hard drop), re-spawn armed.
    int m_wrap [3] = '{0, 1, 0};
    int m_dfr  [3] = '{30, 30, 2};
    int mx [3];
    int my [3];
    int mst [3];
    int mcnt [3];
    int mpend [3];
    int marm [3];

    function automatic int decode(input logic [8:0] c);
        case (c)
            9'h16B:  return 1;
            9'h174:  return 2;
            9'h172:  return 3;
            9'h029:  return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset(input int i);
        mx[i] = 288; my[i] = 0; mst[i] = 0; mcnt[i] = 0; mpend[i] = 0; marm[i] = 0;
    endtask

    task automatic model_step(input int i);
        int nx, ny;
        bit tick, was_landed;
        if (!rst) begin
            model_reset(i);
            return;
        end
        if (frame_start) begin
            mcnt[i] = (mcnt[i] + 1) % m_dfr[i];
            tick = (mcnt[i] == 0);
            nx = mx[i];
            ny = my[i];
            was_landed = (mst[i] == 2);
            if (mst[i] == 0) begin
                if (mpend[i] == 1)
                    nx = (m_wrap[i] != 0 && mx[i] == 0) ? XMAX : ((mx[i] - 16 < 0) ? 0 : mx[i] - 16);
                if (mpend[i] == 2)
                    nx = (m_wrap[i] != 0 && mx[i] == XMAX) ? 0 : ((mx[i] + 16 > XMAX) ? XMAX : mx[i] + 16);
                if (mpend[i] == 3 || tick)
                    ny = (my[i] + 16 > YMAX) ? YMAX : my[i] + 16;
                if (mpend[i] == 4)
                    mst[i] = 1;
            end else if (mst[i] == 1) begin
                ny = (my[i] + 16 > YMAX) ? YMAX : my[i] + 16;
            end else if (marm[i] != 0) begin
                nx = 288; ny = 0; mcnt[i] = 0; marm[i] = 0; mst[i] = 0;
            end
            mx[i] = nx;
            my[i] = ny;
            if (!was_landed && ny == YMAX)
                mst[i] = 2;
            mpend[i] = 0;
        end
        if (key_valid) begin
            if (mst[i] == 2)
                marm[i] = 1;
            else if (decode(key_code) != 0)
                mpend[i] = decode(key_code);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
        key_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic press(input logic [8:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick_cycle();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick_cycle();
        tick_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        press(9'h16B);
        rst = 1'b0;
        frame_start = 1'b1;
        key_valid = 1'b1;
        key_code = 9'h174;
        tick_cycle();
        n_cmp++;
        if ({lm[0], rm[0], um[0], dm[0]} !== {10'd288, 10'd351, 10'd0, 10'd63}) begin
            n_bad++;
            $display("[TB] FAIL reset_bounds: got %0d %0d %0d %0d expected 288 351 0 63", lm[0], rm[0], um[0], dm[0]);
        end
        n_cmp++;
        if ({ld[0], iw[0], pa[0]} !== 19'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_flags: got landed=%0d in_win=%0d addr=%0d expected 0 0 0", ld[0], iw[0], pa[0]);
        end
        rst = 1'b1;
        frame();
        n_cmp++;
        if (lm[0] !== 10'd288) begin
            n_bad++;
            $display("[TB] FAIL reset_pending_cleared: got x=%0d expected 288", lm[0]);
        end
    endtask

    task automatic test_left_move();
        do_reset();
        press(9'h16B);
        n_cmp++;
        if (lm[0] !== 10'd288) begin
            n_bad++;
            $display("[TB] FAIL move_waits_frame: got x=%0d expected 288", lm[0]);
        end
        frame();
        n_cmp++;
        if ({lm[0], rm[0], um[0]} !== {10'd272, 10'd335, 10'd0}) begin
            n_bad++;
            $display("[TB] FAIL left_move: got %0d %0d %0d expected 272 335 0", lm[0], rm[0], um[0]);
        end
        press(9'h16B);
        press(9'h174);
        frame();
        n_cmp++;
        if (lm[0] !== 10'd288) begin
            n_bad++;
            $display("[TB] FAIL last_key_wins: got x=%0d expected 288", lm[0]);
        end
        key_valid = 1'b1;
        key_code = 9'h16B;
        frame_start = 1'b1;
        tick_cycle();
        n_cmp++;
        if (lm[0] !== 10'd288) begin
            n_bad++;
            $display("[TB] FAIL key_with_frame_deferred: got x=%0d expected 288", lm[0]);
        end
        frame();
        n_cmp++;
        if (lm[0] !== 10'd272) begin
            n_bad++;
            $display("[TB] FAIL key_with_frame_applied: got x=%0d expected 272", lm[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 18; k++) begin
            press(9'h16B);
            frame();
        end
        n_cmp++;
        if ({lm[0], lm[1]} !== {10'd0, 10'd0}) begin
            n_bad++;
            $display("[TB] FAIL reach_left_edge: got %0d %0d expected 0 0", lm[0], lm[1]);
        end
        press(9'h16B);
        frame();
        n_cmp++;
        if ({lm[0], lm[1]} !== {10'd0, 10'd576}) begin
            n_bad++;
            $display("[TB] FAIL left_at_edge: got clamp=%0d wrap=%0d expected 0 576", lm[0], lm[1]);
        end
        press(9'h174);
        frame();
        n_cmp++;
        if ({lm[0], lm[1], um[0]} !== {10'd16, 10'd0, 10'd0}) begin
            n_bad++;
            $display("[TB] FAIL right_at_edge: got clamp=%0d wrap=%0d y=%0d expected 16 0 0", lm[0], lm[1], um[0]);
        end
    endtask

    task automatic test_gravity_merge();
        do_reset();
        frame();
        n_cmp++;
        if (um[2] !== 10'd0) begin
            n_bad++;
            $display("[TB] FAIL gravity_first_frame: got y=%0d expected 0", um[2]);
        end
        press(9'h172);
        frame();
        n_cmp++;
        if ({um[2], um[0]} !== {10'd16, 10'd16}) begin
            n_bad++;
            $display("[TB] FAIL down_plus_gravity: got fast=%0d def=%0d expected 16 16", um[2], um[0]);
        end
        frame();
        frame();
        n_cmp++;
        if ({um[2], um[0]} !== {10'd32, 10'd16}) begin
            n_bad++;
            $display("[TB] FAIL gravity_period: got fast=%0d def=%0d expected 32 16", um[2], um[0]);
        end
    endtask

    task automatic test_hard_drop();
        do_reset();
        press(9'h16B);
        frame();
        press(9'h029);
        frame();
        n_cmp++;
        if ({lm[0], um[0]} !== {10'd272, 10'd0}) begin
            n_bad++;
            $display("[TB] FAIL drop_start: got x=%0d y=%0d expected 272 0", lm[0], um[0]);
        end
        for (int k = 1; k <= 26; k++) begin
            if (k == 5)
                press(9'h16B);
            frame();
            n_cmp++;
            if ({lm[0], um[0], ld[0]} !== {10'd272, 10'(16 * k), (k == 26)}) begin
                n_bad++;
                $display("[TB] FAIL drop_step %0d: got x=%0d y=%0d landed=%0d expected 272 %0d %0d",
                         k, lm[0], um[0], ld[0], 16 * k, (k == 26));
            end
        end
        frame();
        press(9'h16B);
        n_cmp++;
        if ({lm[0], um[0], ld[0]} !== {10'd272, 10'd416, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL landed_hold: got x=%0d y=%0d landed=%0d expected 272 416 1", lm[0], um[0], ld[0]);
        end
        frame();
        n_cmp++;
        if ({lm[0], um[0], ld[0]} !== {10'd288, 10'd0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL respawn: got x=%0d y=%0d landed=%0d expected 288 0 0", lm[0], um[0], ld[0]);
        end
    endtask

    task automatic test_pixel();
        int hv [4][2] = '{'{290, 3}, '{352, 3}, '{351, 63}, '{287, 10}};
        int ew [4] = '{1, 0, 1, 0};
        int ea [4] = '{194, 0, 4095, 0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            h_cnt = 10'(hv[k][0]);
            v_cnt = 10'(hv[k][1]);
            tick_cycle();
            n_cmp++;
            if ({iw[0], pa[0]} !== {ew[k] != 0, 17'(ea[k])}) begin
                n_bad++;
                $display("[TB] FAIL pixel h=%0d v=%0d: got in_win=%0d addr=%0d expected %0d %0d",
                         hv[k][0], hv[k][1], iw[0], pa[0], ew[k], ea[k]);
            end
        end
    endtask

    task automatic test_reset_mid_drop();
        do_reset();
        press(9'h029);
        frame();
        frame();
        frame();
        rst = 1'b0;
        frame_start = 1'b1;
        tick_cycle();
        rst = 1'b1;
        n_cmp++;
        if ({lm[0], um[0], ld[0]} !== {10'd288, 10'd0, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_drop: got x=%0d y=%0d landed=%0d expected 288 0 0", lm[0], um[0], ld[0]);
        end
        press(9'h16B);
        frame();
        n_cmp++;
        if ({lm[0], um[0], um[2]} !== {10'd272, 10'd0, 10'd0}) begin
            n_bad++;
            $display("[TB] FAIL fall_after_reset: got x=%0d y=%0d fast_y=%0d expected 272 0 0", lm[0], um[0], um[2]);
        end
    endtask

    task automatic test_random();
        logic [8:0] codes [4] = '{9'h16B, 9'h174, 9'h172, 9'h029};
        int ew [3];
        int ea [3];
        int sel, h, v;
        do_reset();
        for (int i = 0; i < 3; i++)
            model_reset(i);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 299) != 0);
            frame_start = ($urandom_range(0, 3) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 15);
            key_code = (sel < 12) ? codes[sel / 4] : ((sel == 12) ? codes[3] : 9'($urandom));
            h = mx[0] + $urandom_range(0, 80) - 8;
            v = my[0] + $urandom_range(0, 80) - 8;
            h_cnt = 10'((h < 0) ? 0 : h);
            v_cnt = 10'((v < 0) ? 0 : v);
            for (int i = 0; i < 3; i++) begin
                ew[i] = (rst && int'(h_cnt) >= mx[i] && int'(h_cnt) <= mx[i] + 63 &&
                         int'(v_cnt) >= my[i] && int'(v_cnt) <= my[i] + 63) ? 1 : 0;
                ea[i] = ew[i] ? (int'(h_cnt) - mx[i]) + 64 * (int'(v_cnt) - my[i]) : 0;
                model_step(i);
            end
            tick_cycle();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if ({lm[i], rm[i], um[i], dm[i]} !== {10'(mx[i]), 10'(mx[i] + 63), 10'(my[i]), 10'(my[i] + 63)}) begin
                    n_bad++;
                    $display("[TB] FAIL rand_bounds inst%0d cyc%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                             i, cyc, lm[i], rm[i], um[i], dm[i], mx[i], mx[i] + 63, my[i], my[i] + 63);
                end
                n_cmp++;
                if (ld[i] !== (mst[i] == 2)) begin
                    n_bad++;
                    $display("[TB] FAIL rand_landed inst%0d cyc%0d: got %0d expected %0d", i, cyc, ld[i], mst[i] == 2);
                end
                n_cmp++;
                if ({iw[i], pa[i]} !== {ew[i] != 0, 17'(ea[i])}) begin
                    n_bad++;
                    $display("[TB] FAIL rand_pixel inst%0d cyc%0d: got in_win=%0d addr=%0d expected %0d %0d",
                             i, cyc, iw[i], pa[i], ew[i], ea[i]);
                end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        tick_cycle();
        test_reset();
        test_left_move();
        test_wrap();
        test_gravity_merge();
        test_hard_drop();
        test_pixel();
        test_reset_mid_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
